// File: rtl/apb_pkg.sv
// Shared types for the APB master / register-bank pair: command encodings,
// master FSM states and the slave wait-counter width.
package apb_pkg;

   typedef enum logic [1:0] {
      CMD_IDLE  = 2'b00,
      CMD_READ  = 2'b01,
      CMD_WRITE = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10
   } apb_state_e;

   localparam int WAIT_W = 4;

endpackage

// File: rtl/apb_regbank_slave.sv
// APB register-bank slave: programmable wait states, byte-strobed writes,
// and PSLVERR on indices beyond the implemented register count.
module apb_regbank_slave
   import apb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 4,
   parameter int NUM_REGS    = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W/8-1:0] pstrb,
   output logic                pready,
   output logic [DATA_W-1:0]   prdata,
   output logic                pslverr
);

   localparam int               NBYTES = DATA_W / 8;
   localparam logic [ADDR_W:0]  NREGS  = NUM_REGS[ADDR_W:0];
   localparam logic [WAIT_W-1:0] WAIT_L = WAIT_STATES[WAIT_W-1:0];

   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              in_range;
   logic              access;
   logic [DATA_W-1:0] rd_word;

   assign in_range = ({1'b0, paddr} < NREGS);
   assign access   = psel & penable;
   assign pready   = access & (cnt_q == WAIT_L);
   assign pslverr  = pready & ~in_range;
   assign prdata   = in_range ? rd_word : '0;

   // Wait counter: cleared during SETUP, counts ACCESS cycles, holds otherwise.
   always_comb begin
      cnt_d = cnt_q;
      if (psel && !penable) begin
         cnt_d = '0;
      end else if (access) begin
         cnt_d = cnt_q + WAIT_W'(1);
      end
   end

   // Register read mux and strobed write-next computation.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (paddr == i[ADDR_W-1:0]) begin
            rd_word = regs_q[i];
            if (pready && pwrite && in_range) begin
               for (int b = 0; b < NBYTES; b++) begin
                  if (pstrb[b]) begin
                     regs_d[i][8*b +: 8] = pwdata[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Counter and register bank state; reset clears everything.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         cnt_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

endmodule

// File: rtl/apb_regbank_top.sv
// Command-port APB master driving the register-bank slave. One transfer in
// flight at a time; captured command fields stay stable SETUP through ACCESS.
module apb_regbank_top
   import apb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 4,
   parameter int NUM_REGS    = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic [1:0]          cmd_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] strb_i,
   output logic                ready_o,
   output logic                err_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                busy_o
);

   apb_state_e          state_q, state_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] strb_q, strb_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                psel, penable, pready, pslverr;
   logic [DATA_W-1:0]   prdata;

   apb_regbank_slave #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .NUM_REGS    (NUM_REGS),
      .WAIT_STATES (WAIT_STATES)
   ) u_slave (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel),
      .penable (penable),
      .pwrite  (write_q),
      .paddr   (addr_q),
      .pwdata  (wdata_q),
      .pstrb   (strb_q),
      .pready  (pready),
      .prdata  (prdata),
      .pslverr (pslverr)
   );

   assign ready_o = ready_q;
   assign err_o   = err_q;
   assign rdata_o = rdata_q;
   assign busy_o  = (state_q != ST_IDLE);

   // Master next-state, command capture, APB strobes and completion outputs.
   always_comb begin
      state_d = state_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      ready_d = 1'b0;
      err_d   = err_q;
      rdata_d = rdata_q;
      psel    = 1'b0;
      penable = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_i == CMD_READ || cmd_i == CMD_WRITE) begin
               write_d = (cmd_i == CMD_WRITE);
               addr_d  = addr_i;
               wdata_d = wdata_i;
               strb_d  = strb_i;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            psel    = 1'b1;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready) begin
               ready_d = 1'b1;
               err_d   = pslverr;
               if (!write_q && !pslverr) begin
                  rdata_d = prdata;
               end
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Master state, capture and output registers.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_apb_regbank_top.sv
// Directed bench for apb_regbank_top at default parameters.
module tb_apb_regbank_top;

   logic        pclk;
   logic        preset;
   logic [1:0]  cmd_i;
   logic [3:0]  addr_i;
   logic [31:0] wdata_i;
   logic [3:0]  strb_i;
   logic        ready_o;
   logic        err_o;
   logic [31:0] rdata_o;
   logic        busy_o;

   int errors = 0;
   int checks = 0;

   apb_regbank_top #(
      .DATA_W      (32),
      .ADDR_W      (4),
      .NUM_REGS    (8),
      .WAIT_STATES (1)
   ) dut (
      .pclk    (pclk),
      .preset  (preset),
      .cmd_i   (cmd_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .strb_i  (strb_i),
      .ready_o (ready_o),
      .err_o   (err_o),
      .rdata_o (rdata_o),
      .busy_o  (busy_o)
   );

   initial pclk = 1'b0;
   always #10 pclk = ~pclk;

   // Runs one transfer; returns edges from capture to ready_o and the
   // outputs seen in the ready_o cycle. Live inputs are scrambled after capture.
   task automatic xfer(input logic [1:0] c, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output int lat, output logic e, output logic [31:0] rd);
      logic rdy;
      @(negedge pclk);
      cmd_i = c; addr_i = a; wdata_i = d; strb_i = s;
      @(posedge pclk); #1;
      addr_i = a ^ 4'h1; wdata_i = ~d; strb_i = ~s;
      lat = 0; rdy = 1'b0;
      while (!rdy && lat < 40) begin
         @(posedge pclk); #1;
         lat++;
         rdy = ready_o;
      end
      e = err_o; rd = rdata_o;
      cmd_i = 2'b00;
   endtask

   task automatic test_reset();
      preset = 1'b1; cmd_i = 2'b00; addr_i = '0; wdata_i = '0; strb_i = '0;
      repeat (2) @(posedge pclk);
      #1;
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
      checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=00000000", rdata_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      @(negedge pclk); preset = 1'b0;
   endtask

   task automatic test_write_read();
      int lat; logic e; logic [31:0] rd;
      xfer(2'b11, 4'd2, 32'h1234ABCD, 4'hF, lat, e, rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err got=%b exp=0", e); end
      xfer(2'b01, 4'd2, 32'h0, 4'h0, lat, e, rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got=%0d exp=3", lat); end
      checks++; if (rd !== 32'h1234ABCD) begin errors++; $display("FAIL rd_data got=%h exp=1234abcd", rd); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", e); end
   endtask

   task automatic test_strobe();
      int lat; logic e; logic [31:0] rd;
      xfer(2'b11, 4'd2, 32'hFFFFFFFF, 4'b0101, lat, e, rd);
      xfer(2'b01, 4'd2, 32'h0, 4'h0, lat, e, rd);
      checks++; if (rd !== 32'h12FFABFF) begin errors++; $display("FAIL strobe_data got=%h exp=12ffabff", rd); end
   endtask

   task automatic test_out_of_range();
      int lat; logic e; logic [31:0] rd;
      xfer(2'b11, 4'd9, 32'hDEADBEEF, 4'hF, lat, e, rd);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err got=%b exp=1", e); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL oor_wr_latency got=%0d exp=3", lat); end
      xfer(2'b01, 4'd9, 32'h0, 4'h0, lat, e, rd);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_rd_err got=%b exp=1", e); end
      checks++; if (rd !== 32'h12FFABFF) begin errors++; $display("FAIL oor_rd_hold got=%h exp=12ffabff", rd); end
      xfer(2'b01, 4'd0, 32'h0, 4'h0, lat, e, rd);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd0_err got=%b exp=0", e); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd0_data got=%h exp=00000000", rd); end
   endtask

   task automatic test_reset_mid_transfer();
      int lat; logic e; logic [31:0] rd; logic saw_ready;
      @(negedge pclk);
      cmd_i = 2'b11; addr_i = 4'd3; wdata_i = 32'h5678EF01; strb_i = 4'hF;
      @(posedge pclk);
      @(posedge pclk); #1;
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy_access got=%b exp=1", busy_o); end
      #2 preset = 1'b1;
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy_abort got=%b exp=0", busy_o); end
      cmd_i = 2'b00;
      saw_ready = ready_o;
      repeat (3) begin
         @(posedge pclk); #1;
         saw_ready = saw_ready | ready_o;
      end
      @(negedge pclk); preset = 1'b0;
      repeat (3) begin
         @(posedge pclk); #1;
         saw_ready = saw_ready | ready_o;
      end
      checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL mid_no_ready got=%b exp=0", saw_ready); end
      xfer(2'b01, 4'd3, 32'h0, 4'h0, lat, e, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rd3 got=%h exp=00000000", rd); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL mid_rd_latency got=%0d exp=3", lat); end
   endtask

   task automatic test_back_to_back();
      int lat; logic e; logic [31:0] rd;
      int first, second, k; logic bad_busy;
      xfer(2'b11, 4'd2, 32'hA5A5A5A5, 4'hF, lat, e, rd);
      @(negedge pclk);
      cmd_i = 2'b01; addr_i = 4'd2; wdata_i = 32'h0; strb_i = 4'h0;
      @(posedge pclk); #1;
      first = -1; second = -1; bad_busy = 1'b0; k = 0;
      while (second < 0 && k < 30) begin
         if (busy_o !== ~ready_o) bad_busy = 1'b1;
         if (ready_o === 1'b1) begin
            if (first < 0) first = k; else second = k;
         end
         if (second < 0) begin
            @(posedge pclk); #1;
            k++;
         end
      end
      cmd_i = 2'b00;
      checks++; if (first !== 3) begin errors++; $display("FAIL b2b_first got=%0d exp=3", first); end
      checks++; if (second - first !== 4) begin errors++; $display("FAIL b2b_spacing got=%0d exp=4", second - first); end
      checks++; if (bad_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got=%b exp=0", bad_busy); end
      checks++; if (rdata_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_rdata got=%h exp=a5a5a5a5", rdata_o); end
   endtask

   task automatic test_reserved_cmd();
      int lat; logic e; logic [31:0] rd; logic active;
      @(negedge pclk);
      cmd_i = 2'b10; addr_i = 4'd2; wdata_i = 32'h0; strb_i = 4'hF;
      active = 1'b0;
      repeat (5) begin
         @(posedge pclk); #1;
         active = active | busy_o | ready_o;
      end
      cmd_i = 2'b00;
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL rsv_activity got=%b exp=0", active); end
      xfer(2'b01, 4'd2, 32'h0, 4'h0, lat, e, rd);
      checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL rsv_reg_intact got=%h exp=a5a5a5a5", rd); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_strobe();
      test_out_of_range();
      test_reset_mid_transfer();
      test_back_to_back();
      test_reserved_cmd();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
